// File: rtl/uart_pkg.sv
// Shared encodings and widths for the byte-serial UART transmitter.
package uart_pkg;

  localparam int STATE_W = 2;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = 3;

  // Debug probes rely on this exact encoding.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic trig
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // The tick is combinational so the FSM can change state on the same edge that ends the bit.
  assign trig = enable && (cnt == LAST);

  // Free-run while enabled, wrap after the last cycle, park at zero otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       cnt <= '0;
    else if (clear)   cnt <= '0;
    else if (!enable) cnt <= '0;
    else if (trig)    cnt <= '0;
    else              cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter: accepts a byte on valid/ready, then shifts start, 8 data bits LSB first, stop.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               tx,
  output logic               trig,
  output logic               tc,
  output logic [STATE_W-1:0] present_state,
  output logic [IDX_W-1:0]   data_ind
);

  state_t             state, state_nxt;
  logic [DATA_W-1:0]  shreg, shreg_nxt;
  logic [IDX_W-1:0]   ind_nxt;
  logic               tx_nxt;
  logic               accept;

  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .enable (state != IDLE),
    .trig   (trig)
  );

  assign ready_o       = (state == IDLE);
  assign tc            = trig && (state == STOP);
  assign present_state = state;

  // State register plus the registered line and bit index, all reset to the idle picture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      shreg    <= '0;
      data_ind <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      shreg    <= shreg_nxt;
      data_ind <= ind_nxt;
      tx       <= tx_nxt;
    end
  end

  // Next state / index, and the line level that belongs to the next state so tx lines up with it.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    ind_nxt   = data_ind;
    accept    = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      IDLE: if (valid_i) begin
        accept    = 1'b1;
        state_nxt = START;
        shreg_nxt = data_i;
        ind_nxt   = '0;
      end
      START: if (trig) state_nxt = DATA;
      DATA: if (trig) begin
        if (data_ind == IDX_W'(7)) begin
          state_nxt = STOP;
          ind_nxt   = '0;
        end else begin
          ind_nxt   = data_ind + IDX_W'(1);
        end
      end
      STOP: if (trig) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shreg_nxt[ind_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at 4 clocks per bit: frame table plus hand-written corner cases.
module tb_uart_byte_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o, tx, trig, tc;
  logic [1:0] present_state;
  logic [2:0] data_ind;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic [9:0] seq;     // line levels, seq[9] first: start, b0..b7, stop
    int         glitch;  // cycle in frame to pulse valid_i with 0x3C, 0 = none
  } vec_t;

  vec_t vecs[6];

  uart_byte_tx #(.CLKS_PER_BIT(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_i        (data_i),
    .valid_i       (valid_i),
    .ready_o       (ready_o),
    .tx            (tx),
    .trig          (trig),
    .tc            (tc),
    .present_state (present_state),
    .data_ind      (data_ind)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in cycle 1 of a frame (just after the accept edge); leaves in cycle 41 (idle).
  task automatic watch_frame(input logic [9:0] seq, input string nm, input int glitch);
    int cyc;
    for (int k = 0; k < 10; k++) begin
      for (int c = 0; c < 4; c++) begin
        cyc = k * 4 + c + 1;
        chk({nm, " tx"}, {7'd0, tx}, {7'd0, seq[9-k]});
        chk({nm, " trig"}, {7'd0, trig}, {7'd0, c == 3});
        chk({nm, " tc"}, {7'd0, tc}, {7'd0, (k == 9) && (c == 3)});
        chk({nm, " ready"}, {7'd0, ready_o}, 8'd0);
        chk({nm, " state"}, {6'd0, present_state}, (k == 0) ? 8'd1 : (k == 9) ? 8'd3 : 8'd2);
        chk({nm, " data_ind"}, {5'd0, data_ind}, (k >= 1 && k <= 8) ? 8'(k - 1) : 8'd0);
        if (glitch != 0 && cyc == glitch) begin
          valid_i = 1'b1;
          data_i  = 8'h3C;
        end else if (glitch != 0 && cyc == glitch + 1) begin
          valid_i = 1'b0;
          data_i  = 8'h00;
        end
        tick();
      end
    end
    chk({nm, " idle ready"}, {7'd0, ready_o}, 8'd1);
    chk({nm, " idle tx"}, {7'd0, tx}, 8'd1);
    chk({nm, " idle state"}, {6'd0, present_state}, 8'd0);
    chk({nm, " idle trig"}, {7'd0, trig}, 8'd0);
    chk({nm, " idle tc"}, {7'd0, tc}, 8'd0);
  endtask

  task automatic send(input logic [7:0] d, input logic [9:0] seq, input string nm, input int glitch);
    valid_i = 1'b1;
    data_i  = d;
    tick();
    valid_i = 1'b0;
    data_i  = 8'h00;
    watch_frame(seq, nm, glitch);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, " tx"}, {7'd0, tx}, 8'd1);
    chk({nm, " state"}, {6'd0, present_state}, 8'd0);
    chk({nm, " ready"}, {7'd0, ready_o}, 8'd1);
    chk({nm, " trig"}, {7'd0, trig}, 8'd0);
    chk({nm, " tc"}, {7'd0, tc}, 8'd0);
    chk({nm, " data_ind"}, {5'd0, data_ind}, 8'd0);
  endtask

  initial begin
    logic bad_tx, bad_trig, bad_tc;

    vecs[0] = '{8'hA5, 10'b0_10100101_1, 0};
    vecs[1] = '{8'h00, 10'b0_00000000_1, 0};
    vecs[2] = '{8'hFF, 10'b0_11111111_1, 0};
    vecs[3] = '{8'h81, 10'b0_10000001_1, 15};
    vecs[4] = '{8'h55, 10'b0_10101010_1, 0};
    vecs[5] = '{8'h3C, 10'b0_00111100_1, 0};

    reset   = 1'b0;
    valid_i = 1'b0;
    data_i  = 8'h00;
    #12;
    chk_reset_outputs("reset");
    #1;
    reset = 1'b1;

    // First vector is offered straight out of reset, so it is accepted on the first edge.
    for (int i = 0; i < 6; i++)
      send(vecs[i].data, vecs[i].seq, $sformatf("vec%0d", i), vecs[i].glitch);

    // Quiet line with no traffic.
    bad_tx = 1'b0; bad_trig = 1'b0; bad_tc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (tx !== 1'b1)   bad_tx   = 1'b1;
      if (trig !== 1'b0) bad_trig = 1'b1;
      if (tc !== 1'b0)   bad_tc   = 1'b1;
      tick();
    end
    chk("idle100 tx", {7'd0, bad_tx}, 8'd0);
    chk("idle100 trig", {7'd0, bad_trig}, 8'd0);
    chk("idle100 tc", {7'd0, bad_tc}, 8'd0);

    // Back-to-back with valid held: 0x00 then 0xFF, one idle cycle between frames.
    valid_i = 1'b1;
    data_i  = 8'h00;
    tick();
    data_i  = 8'hFF;
    watch_frame(10'b0_00000000_1, "b2b0", 0);
    tick();
    valid_i = 1'b0;
    watch_frame(10'b0_11111111_1, "b2b1", 0);

    // Abort mid-frame at data_ind 3, asynchronously.
    valid_i = 1'b1;
    data_i  = 8'hFF;
    tick();
    valid_i = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    chk("pre-abort data_ind", {5'd0, data_ind}, 8'd3);
    chk("pre-abort state", {6'd0, present_state}, 8'd2);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    chk_reset_outputs("abort held");
    #3;
    reset = 1'b1;
    send(8'h55, 10'b0_10101010_1, "post-abort", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute bound so a stuck run still reports.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/uart_byte_tx.md
UART_BYTE_TX -- requirements
Module: uart_byte_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 234 (27 MHz / 115200 baud), which sets the clock cycles per serial bit and must be 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port data_i, input, 8 bits: the byte to transmit.
REQ-005 The block SHALL have port valid_i, input, 1 bit: data_i is offered.
REQ-006 The block SHALL have port ready_o, output, 1 bit: the block can accept a byte.
REQ-007 The block SHALL have port tx, output, 1 bit: the serial line, idle high.
REQ-008 The block SHALL have port trig, output, 1 bit: a one-cycle baud tick at the end of each bit period.
REQ-009 The block SHALL have port tc, output, 1 bit: a one-cycle pulse when a frame completes.
REQ-010 The block SHALL have port present_state, output, 2 bits: the current FSM state, exported for the debug probe.
REQ-011 The block SHALL have port data_ind, output, 3 bits: the index of the data bit being sent, exported for the debug probe.

Function
REQ-012 The FSM SHALL have states IDLE=0, START=1, DATA=2, STOP=3, and present_state SHALL be registered.
REQ-013 ready_o SHALL equal (present_state==IDLE); a byte is accepted on a rising edge where valid_i and ready_o are both 1.
REQ-014 On accept, the block SHALL latch data_i into an internal shift register, clear the baud counter and set data_ind=0; the state SHALL be START in the following cycle.
REQ-015 The baud counter SHALL run 0..CLKS_PER_BIT-1 while not in IDLE, and trig SHALL be 1 in the cycle the counter equals CLKS_PER_BIT-1; the counter SHALL hold at 0 and trig SHALL be 0 in IDLE.
REQ-016 The state SHALL transition on a trig cycle: START->DATA; DATA->DATA while data_ind<7, incrementing data_ind; DATA->STOP at data_ind==7 with data_ind wrapping to 0; STOP->IDLE.
REQ-017 tx SHALL be registered: 1 in IDLE and STOP, 0 in START, and latched_data[data_ind] in DATA (LSB first); each level SHALL last exactly CLKS_PER_BIT cycles.
REQ-018 tc SHALL pulse for one cycle, coincident with trig in STOP; ready_o SHALL rise in the next cycle.
REQ-019 An accept-to-ready frame SHALL take 10*CLKS_PER_BIT cycles; with valid_i held high, back-to-back frames SHALL have a period of 10*CLKS_PER_BIT+1 cycles, including one idle-high cycle.
REQ-020 valid_i and data_i SHALL be ignored while ready_o=0; changes to data_i mid-frame SHALL NOT affect tx.
REQ-021 A reset assertion mid-frame SHALL abort the frame immediately, with no partial stop bit.

Reset
REQ-022 While reset=0 the outputs SHALL be: present_state=IDLE, tx=1, ready_o=1, trig=0, tc=0, data_ind=0; the baud counter and shift register SHALL be 0.
REQ-023 The first accept SHALL be possible on the first rising edge after reset deasserts.

Structure
REQ-024 The shared package uart_pkg SHALL hold the state encoding (IDLE/START/DATA/STOP), the state width 2, the data width 8 and the index width 3.
REQ-025 There SHALL be one sub-module, uart_baud_tick: a counter with parameter CLKS_PER_BIT, inputs clk, reset, clear and enable, and output trig.
REQ-026 The counter width SHALL be $clog2(CLKS_PER_BIT).

Verification (CLKS_PER_BIT=4)
REQ-027 Send 0xA5 -> tx shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tc pulses once at cycle 40 after accept; ready_o returns at cycle 41.
REQ-028 Hold valid_i=1 with 0x00 then 0xFF -> the second start bit begins 41 cycles after the first; exactly 1 idle-high cycle occurs between frames.
REQ-029 Pulse valid_i with data_i=0x3C during DATA of a 0x81 frame -> tx carries only 0x81; 0x3C is never transmitted.
REQ-030 Assert reset at data_ind=3 -> tx=1, present_state=0, ready_o=1 asynchronously; a subsequent 0x55 frame is bit-exact.
REQ-031 In IDLE with valid_i=0 for 100 cycles -> tx stays 1; trig and tc stay 0.
REQ-032 Across any frame -> trig pulses exactly 10 times per frame, spaced 4 cycles apart, and data_ind steps 0..7 only while in DATA.
